// File: rtl/brake_signal_conditioner.sv
// brake_signal_conditioner
//
// Turns the raw, bouncy brake-lever switch into the clean brakeActive level
// for the brake light PWM controller. The switch is synchronized into the
// c50M domain and debounced. With the flash option built in, each new
// debounced press produces an attention-flash burst before steady-on.
//
// Build option:
//   BRAKE_FLASH_EN  defined   -> flash burst FSM (IDLE/FLASH_ON/FLASH_OFF/STEADY)
//                   undefined -> brakeActive is the debounced level, one cycle
//                                late (same latency as the flash build);
//                                flashing is tied low
//
// Parameters:
//   DEBOUNCE_CYCLES    stable cycles needed to accept a switch change (>= 1)
//   FLASH_HALF_CYCLES  length of each on and each off phase (>= 1)
//   FLASH_COUNT        on pulses per burst (>= 1)
//
// Ports:
//   c50M            in   50 MHz clock, the only clock
//   reset_n         in   asynchronous active-low reset
//   brakeSwitchRaw  in   raw lever switch, asynchronous, 1 = pressed
//   brakeActive     out  level for the brake light controller
//   brakeHeld       out  debounced lever level
//   flashing        out  1 while a burst is in progress

module brake_signal_conditioner #(
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int FLASH_HALF_CYCLES = 3125000,
   parameter int FLASH_COUNT       = 4
) (
   input  logic c50M,
   input  logic reset_n,
   input  logic brakeSwitchRaw,
   output logic brakeActive,
   output logic brakeHeld,
   output logic flashing
);

   if (DEBOUNCE_CYCLES < 1 || FLASH_HALF_CYCLES < 1 || FLASH_COUNT < 1) begin : gBadParams
      $error("brake_signal_conditioner: all parameters must be >= 1");
   end

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1;
   logic            sync2;
   logic [DB_W-1:0] dbCnt;

   // Two-flop synchronizer for the asynchronous switch
   always_ff @(posedge c50M or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= brakeSwitchRaw;
         sync2 <= sync1;
      end
   end

   // Debounce: any cycle of agreement restarts the count, so only a
   // disagreement lasting DEBOUNCE_CYCLES consecutive cycles is accepted.
   always_ff @(posedge c50M or negedge reset_n) begin
      if (!reset_n) begin
         dbCnt     <= '0;
         brakeHeld <= 1'b0;
      end else if (sync2 == brakeHeld) begin
         dbCnt <= '0;
      end else if (dbCnt == DB_LAST) begin
         dbCnt     <= '0;
         brakeHeld <= sync2;
      end else begin
         dbCnt <= dbCnt + DB_W'(1);
      end
   end

`ifdef BRAKE_FLASH_EN

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FLASH_ON  = 2'd1,
      FLASH_OFF = 2'd2,
      STEADY    = 2'd3
   } flashState_e;

   // A single-cycle phase still needs a 1-bit timer
   localparam int PH_W = (FLASH_HALF_CYCLES > 1) ? $clog2(FLASH_HALF_CYCLES) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(FLASH_HALF_CYCLES - 1);
   localparam int PC_W = $clog2(FLASH_COUNT + 1);
   localparam logic [PC_W-1:0] PC_TOTAL = PC_W'(FLASH_COUNT);

   flashState_e     state;
   flashState_e     nextState;
   logic [PH_W-1:0] phaseTmr;
   logic [PC_W-1:0] pulseCnt;
   logic [PC_W-1:0] pulseNext;
   logic            phaseDone;
   logic            heldPrev;

   assign phaseDone = (phaseTmr == PH_LAST);
   assign pulseNext = pulseCnt + PC_W'(1);

   always_comb begin
      nextState = state;
      if (!brakeHeld) begin
         // Release wins over every other transition
         nextState = IDLE;
      end else begin
         case (state)
            IDLE:      if (!heldPrev) nextState = FLASH_ON;
            FLASH_ON:  if (phaseDone) nextState = FLASH_OFF;
            FLASH_OFF: if (phaseDone) nextState = (pulseNext == PC_TOTAL) ? STEADY : FLASH_ON;
            default:   nextState = STEADY;
         endcase
      end
   end

   // Outputs are registered from nextState so they change with the state
   always_ff @(posedge c50M or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         phaseTmr    <= '0;
         pulseCnt    <= '0;
         heldPrev    <= 1'b0;
         brakeActive <= 1'b0;
         flashing    <= 1'b0;
      end else begin
         state    <= nextState;
         heldPrev <= brakeHeld;

         if (nextState != state) begin
            phaseTmr <= '0;
         end else if (state == FLASH_ON || state == FLASH_OFF) begin
            phaseTmr <= phaseTmr + PH_W'(1);
         end

         // Clearing while idle guarantees every burst starts from pulse one
         if (state == IDLE) begin
            pulseCnt <= '0;
         end else if (state == FLASH_OFF && phaseDone) begin
            pulseCnt <= pulseNext;
         end

         brakeActive <= (nextState == FLASH_ON) || (nextState == STEADY);
         flashing    <= (nextState == FLASH_ON) || (nextState == FLASH_OFF);
      end
   end

`else

   // Extra register keeps press/release latency equal to the flash build
   always_ff @(posedge c50M or negedge reset_n) begin
      if (!reset_n) begin
         brakeActive <= 1'b0;
      end else begin
         brakeActive <= brakeHeld;
      end
   end

   assign flashing = 1'b0;

`endif

endmodule
